b02_serial_ctrl: RTL and testbench

- Sequential controller around the combinational b02 serial-line recognizer core: owns the 3-bit state register the core lacks, serialises parallel words onto the LINEA line one bit per clock, collects the U output stream into a result word and counts detections.
- Sits between a word-level valid/ready producer/consumer and the core instance.
- Also the natural hook for state-register fault injection in reliability campaigns.

---
 rtl/b02_ctrl_pkg.sv | 17 +
 rtl/b02_ctrl_shifter.sv | 58 +++++
 rtl/b02_serial_ctrl.sv | 147 ++++++++++++++
 tb/tb_b02_serial_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b02_ctrl_pkg.sv
// b02_ctrl_pkg: shared definitions for the b02 serial-line controller.
// Holds the controller FSM encoding, the recognizer state width and the
// recognizer reset state.
package b02_ctrl_pkg;

   // Controller FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_state_e;

   // Recognizer state register width and its reset value
   localparam int unsigned              STATE_W   = 3;
   localparam logic [STATE_W-1:0]       RST_STATE = 3'b000;

endpackage

// File: rtl/b02_ctrl_shifter.sv
// b02_ctrl_shifter: word latch, bit index and result assembly for the b02
// serial controller.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   i_load          latch i_data, clear result and bit index
//   i_shift         advance one serial bit, capture i_u into the result
//   i_data          parallel word, transmitted MSB first
//   i_u             recognizer U output for the current bit
//   o_linea         registered serial bit driven to the recognizer
//   o_result        collected U bits, first bit ends in MSB
//   o_last_c        current shift cycle is the last bit of the word
module b02_ctrl_shifter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_u,
   output logic             o_linea,
   output logic [WIDTH-1:0] o_result,
   output logic             o_last_c
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] r_result;
   logic [IDX_W-1:0] r_idx;
   logic             r_linea;

   // Word is kept rotated so its MSB always holds the next bit to send;
   // rotating rather than shifting keeps every stored bit in use.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_word   <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_linea  <= 1'b0;
      end else if (i_load) begin
         r_word   <= {i_data[WIDTH-2:0], i_data[WIDTH-1]};
         r_linea  <= i_data[WIDTH-1];
         r_result <= '0;
         r_idx    <= '0;
      end else if (i_shift) begin
         r_linea  <= o_last_c ? 1'b0 : r_word[WIDTH-1];
         r_word   <= {r_word[WIDTH-2:0], r_word[WIDTH-1]};
         r_result <= {r_result[WIDTH-2:0], i_u};
         r_idx    <= r_idx + IDX_W'(1);
      end
   end

   assign o_last_c = (r_idx == IDX_W'(WIDTH - 1));
   assign o_linea  = r_linea;
   assign o_result = r_result;

endmodule

// File: rtl/b02_serial_ctrl.sv
// b02_serial_ctrl: sequential controller around the combinational b02
// serial-line recognizer. Owns the recognizer state register, serialises
// accepted words onto LINEA one bit per clock, collects U into a result word
// and keeps a saturating count of U=1 samples.
// Optional state injection is enabled by defining B02_STATE_INJECT_EN.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   in_valid/in_ready       input word handshake; in_data sent MSB first
//   in_restart              with an accepted word, zero the recognizer state
//   out_valid/out_ready     result word handshake; out_data first bit in MSB
//   hit_cnt, clr_cnt        saturating U=1 counter and its synchronous clear
//   core_linea, core_state  drive recognizer LINEA and state inputs
//   core_u, core_next       recognizer U and next-state outputs
//   inj_en, inj_state       (B02_STATE_INJECT_EN) force core_state
//   inj_active              (B02_STATE_INJECT_EN) one-cycle pulse after inject
module b02_serial_ctrl
   import b02_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_restart,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [CNT_W-1:0]   hit_cnt,
   input  logic               clr_cnt,
   output logic               core_linea,
   output logic [STATE_W-1:0] core_state,
   input  logic               core_u,
   input  logic [STATE_W-1:0] core_next
`ifdef B02_STATE_INJECT_EN
   ,
   input  logic               inj_en,
   input  logic [STATE_W-1:0] inj_state,
   output logic               inj_active
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ctrl_state_e        r_state;
   ctrl_state_e        w_state_nxt;
   logic               w_accept;
   logic               w_shift;
   logic               w_last;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [CNT_W-1:0]   r_hit_cnt;
   logic [STATE_W-1:0] r_core_state;
   logic [STATE_W-1:0] w_core_state_nxt;

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes; r_in_ready gates accept so nothing is
   // taken in the cycle reset is released.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_in_ready && in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_shift = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Recognizer state update; injection has the highest priority.
   always_comb begin
      w_core_state_nxt = r_core_state;
      if (w_shift)                     w_core_state_nxt = core_next;
      else if (w_accept && in_restart) w_core_state_nxt = RST_STATE;
`ifdef B02_STATE_INJECT_EN
      if (inj_en)                      w_core_state_nxt = inj_state;
`endif
   end

   // Registered handshakes, recognizer state and detection counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_core_state <= RST_STATE;
         r_hit_cnt    <= '0;
      end else begin
         r_in_ready   <= (w_state_nxt == IDLE);
         r_out_valid  <= (w_state_nxt == DONE);
         r_core_state <= w_core_state_nxt;
         if (clr_cnt)
            r_hit_cnt <= '0;
         else if (w_shift && core_u && (r_hit_cnt != CNT_MAX))
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
   end

`ifdef B02_STATE_INJECT_EN
   logic r_inj_active;

   // One-cycle marker following each injection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_inj_active <= 1'b0;
      else          r_inj_active <= inj_en;
   end

   assign inj_active = r_inj_active;
`endif

   b02_ctrl_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_load   (w_accept),
      .i_shift  (w_shift),
      .i_data   (in_data),
      .i_u      (core_u),
      .o_linea  (core_linea),
      .o_result (out_data),
      .o_last_c (w_last)
   );

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign hit_cnt    = r_hit_cnt;
   assign core_state = r_core_state;

endmodule

// File: tb/tb_b02_serial_ctrl.sv
// tb_b02_serial_ctrl: directed plus randomized bench for b02_serial_ctrl.
// Two instances share stimulus: one with the default 16-bit counter and one
// with a 3-bit counter for saturation. Each drives a stub recognizer:
// next = {state[1:0], linea}, U = (state == 7).
module tb_b02_serial_ctrl;

   logic       clock;
   logic       reset_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_restart;
   logic       out_ready;
   logic       clr_cnt;

   logic        a_in_ready, a_out_valid, a_core_linea, a_core_u;
   logic [7:0]  a_out_data;
   logic [15:0] a_hit_cnt;
   logic [2:0]  a_core_state, a_core_next;

   logic        b_in_ready, b_out_valid, b_core_linea, b_core_u;
   logic [7:0]  b_out_data;
   logic [2:0]  b_hit_cnt;
   logic [2:0]  b_core_state, b_core_next;

`ifdef B02_STATE_INJECT_EN
   logic       inj_en;
   logic [2:0] inj_state;
   logic       a_inj_active, b_inj_active;
`endif

   int checks;
   int errors;

   // Reference state of the scoreboard
   logic [2:0] m_state;
   int         m_hit16;
   int         m_hit3;

   assign a_core_next = {a_core_state[1:0], a_core_linea};
   assign a_core_u    = (a_core_state == 3'b111);
   assign b_core_next = {b_core_state[1:0], b_core_linea};
   assign b_core_u    = (b_core_state == 3'b111);

   b02_serial_ctrl #(.WIDTH(8), .CNT_W(16)) dut_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (a_in_ready),
      .in_data    (in_data),
      .in_restart (in_restart),
      .out_valid  (a_out_valid),
      .out_ready  (out_ready),
      .out_data   (a_out_data),
      .hit_cnt    (a_hit_cnt),
      .clr_cnt    (clr_cnt),
      .core_linea (a_core_linea),
      .core_state (a_core_state),
      .core_u     (a_core_u),
      .core_next  (a_core_next)
`ifdef B02_STATE_INJECT_EN
      ,
      .inj_en     (inj_en),
      .inj_state  (inj_state),
      .inj_active (a_inj_active)
`endif
   );

   b02_serial_ctrl #(.WIDTH(8), .CNT_W(3)) dut_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (b_in_ready),
      .in_data    (in_data),
      .in_restart (in_restart),
      .out_valid  (b_out_valid),
      .out_ready  (out_ready),
      .out_data   (b_out_data),
      .hit_cnt    (b_hit_cnt),
      .clr_cnt    (clr_cnt),
      .core_linea (b_core_linea),
      .core_state (b_core_state),
      .core_u     (b_core_u),
      .core_next  (b_core_next)
`ifdef B02_STATE_INJECT_EN
      ,
      .inj_en     (inj_en),
      .inj_state  (inj_state),
      .inj_active (b_inj_active)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Run-time guard
   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a_ready"}, 32'(a_in_ready), 0);
      chk({tag, "_a_valid"}, 32'(a_out_valid), 0);
      chk({tag, "_a_data"},  32'(a_out_data), 0);
      chk({tag, "_a_hit"},   32'(a_hit_cnt), 0);
      chk({tag, "_a_state"}, 32'(a_core_state), 0);
      chk({tag, "_a_linea"}, 32'(a_core_linea), 0);
      chk({tag, "_b_hit"},   32'(b_hit_cnt), 0);
      chk({tag, "_b_data"},  32'(b_out_data), 0);
   endtask

   task automatic wait_ready(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (!a_in_ready && n < 6) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_ready"}, 32'(a_in_ready), 1);
      if (exp_cycles >= 0) chk({tag, "_ready_cycles"}, 32'(n), 32'(exp_cycles));
   endtask

   // Send one word and check it against the scoreboard. clr_k, rst_k and
   // inj_k select a shift cycle for a counter clear, a reset or an injection
   // (negative = none). Called at a falling edge with the controller in IDLE.
   task automatic run_word(input logic [7:0] d, input bit rs, input int hold,
                           input int clr_k, input int rst_k,
                           input int inj_k, input logic [2:0] inj_val);
      logic [2:0] s;
      logic [7:0] e_res;
      logic       u;
      int         e_h16, e_h3;

      // Expected result: walk the word bit by bit through the stub recognizer
      s     = rs ? 3'b000 : m_state;
      e_res = 8'h00;
      e_h16 = m_hit16;
      e_h3  = m_hit3;
      for (int k = 0; k < 8; k++) begin
         u = (s == 3'b111);
         e_res[7-k] = u;
         if (k == clr_k) begin
            e_h16 = 0;
            e_h3  = 0;
         end else if (u) begin
            if (e_h16 < 65535) e_h16++;
            if (e_h3 < 7)      e_h3++;
         end
         if (k == inj_k) s = inj_val;
         else            s = {s[1:0], d[7-k]};
      end

      chk("accept_ready", 32'(a_in_ready), 1);
      in_valid   = 1'b1;
      in_data    = d;
      in_restart = rs;
      @(negedge clock);
      in_restart = 1'b0;
      in_data    = 8'($urandom);

      for (int k = 0; k < 8; k++) begin
         if (k == rst_k) begin
            #2 reset_n = 1'b0;
            #1;
            chk_all_zero("mid_reset");
            m_state    = 3'b000;
            m_hit16    = 0;
            m_hit3     = 0;
            in_valid   = 1'b0;
            clr_cnt    = 1'b0;
            out_ready  = 1'b0;
`ifdef B02_STATE_INJECT_EN
            inj_en     = 1'b0;
`endif
            @(negedge clock);
            reset_n = 1'b1;
            wait_ready("post_reset", 1);
            return;
         end
         chk("linea", 32'(a_core_linea), 32'(d[7-k]));
         chk("shift_ready", 32'(a_in_ready), 0);
         if (k == 7) chk("valid_early", 32'(a_out_valid), 0);
`ifdef B02_STATE_INJECT_EN
         if (inj_k >= 0 && k == inj_k + 1) chk("inj_active_hi", 32'(a_inj_active), 1);
         if (inj_k >= 0 && k == inj_k + 2) chk("inj_active_lo", 32'(a_inj_active), 0);
         inj_en    = (k == inj_k);
         inj_state = inj_val;
`endif
         in_valid  = 1'($urandom);
         clr_cnt   = (k == clr_k);
         out_ready = (k == 7) ? (hold == 0) : 1'($urandom);
         @(negedge clock);
      end
      clr_cnt  = 1'b0;
      in_valid = 1'b0;
`ifdef B02_STATE_INJECT_EN
      inj_en   = 1'b0;
`endif

      // Accept + WIDTH + 1 cycles: result delivered
      chk("out_valid", 32'(a_out_valid), 1);
      chk("out_data",  32'(a_out_data), 32'(e_res));
      chk("hit16",     32'(a_hit_cnt), 32'(e_h16));
      chk("hit3",      32'(b_hit_cnt), 32'(e_h3));
      chk("b_out_data", 32'(b_out_data), 32'(e_res));
      chk("core_state", 32'(a_core_state), 32'(s));
      chk("done_linea", 32'(a_core_linea), 0);
      chk("done_ready", 32'(a_in_ready), 0);

      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         @(negedge clock);
         chk("hold_valid", 32'(a_out_valid), 1);
         chk("hold_data",  32'(a_out_data), 32'(e_res));
         chk("hold_ready", 32'(a_in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      chk("release_valid", 32'(a_out_valid), 0);
      chk("release_ready", 32'(a_in_ready), 1);
      out_ready = 1'b0;

      m_state = s;
      m_hit16 = e_h16;
      m_hit3  = e_h3;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      m_state    = 3'b000;
      m_hit16    = 0;
      m_hit3     = 0;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      in_restart = 1'b0;
      out_ready  = 1'b0;
      clr_cnt    = 1'b0;
`ifdef B02_STATE_INJECT_EN
      inj_en     = 1'b0;
      inj_state  = 3'b000;
`endif

      // Reset state, including in_ready held low while reset is asserted
      in_valid = 1'b1;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1 chk("ready_at_release", 32'(a_in_ready), 0);
      @(negedge clock);
      chk("ready_first_cycle", 32'(a_in_ready), 1);

      // Directed words
      run_word(8'hFF, 1'b1, 0,  -1, -1, -1, 3'b000);
      run_word(8'h00, 1'b0, 0,  -1, -1, -1, 3'b000);
      run_word(8'hFF, 1'b1, 20, -1, -1, -1, 3'b000);
      run_word(8'h00, 1'b1, 0,  -1, -1, -1, 3'b000);
      // Counter clear on a U=1 shift cycle
      run_word(8'hFF, 1'b1, 0,   4, -1, -1, 3'b000);
      // Saturation of the narrow counter
      for (int i = 0; i < 3; i++) run_word(8'hFF, 1'b1, 0, -1, -1, -1, 3'b000);

      // Randomized words
      for (int i = 0; i < 14; i++)
         run_word(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  -1, -1, -1, 3'b000);

      // Reset in the middle of a word, then recover
      run_word(8'($urandom), 1'b0, 0, -1, 4, -1, 3'b000);
      run_word(8'hFF, 1'b1, 0, -1, -1, -1, 3'b000);

`ifdef B02_STATE_INJECT_EN
      run_word(8'h00, 1'b1, 0, -1, -1, 0, 3'b111);
      run_word(8'($urandom), 1'b0, 1, -1, -1, 3, 3'($urandom));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
